// File: rtl/bus_resp.sv
// bus_resp: CPU bus responder with zero-wait internal RAM pages and a request/ack external port.
// Optional ext_ack timeout with a sticky err flag is built when BUS_RESP_TIMEOUT_EN is defined.
module bus_resp #(
    parameter int RAM_PAGES = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] AB,
    input  logic [7:0]  DO,
    input  logic        WE,
    output logic [7:0]  DB,
    output logic        RDY,
    output logic        ext_req,
    input  logic        ext_ack,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    output logic        ext_we,
    input  logic [7:0]  ext_rdata,
    output logic        err
);

    // Handshakes: the CPU cycle on AB/WE/DO is taken at a rising edge where RDY=1 and ignored
    // otherwise; ext_req is level-held with stable ext_* until a one-cycle ext_ack is sampled.
    localparam int         ADDR_W     = $clog2(RAM_PAGES * 256);
    localparam logic [8:0] PAGE_LIMIT = 9'(RAM_PAGES);

    typedef enum logic {
        IDLE     = 1'b0,
        EXT_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  db_q, db_d;
    logic        ext_req_q, ext_req_d;
    logic [15:0] ext_addr_q, ext_addr_d;
    logic [7:0]  ext_wdata_q, ext_wdata_d;
    logic        ext_we_q, ext_we_d;

    logic [7:0]        mem [RAM_PAGES * 256];
    logic              is_int;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_idx;

    assign is_int  = {1'b0, AB[15:8]} < PAGE_LIMIT;
    assign ram_idx = AB[ADDR_W-1:0];
    assign ram_we  = (state_q == IDLE) && is_int && WE;

`ifdef BUS_RESP_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        db_d        = db_q;
        ext_req_d   = ext_req_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        ext_we_d    = ext_we_q;
`ifdef BUS_RESP_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        if (state_q == IDLE) begin
            if (is_int) begin
                // Read-before-write: DB gets the old contents even on a write cycle.
                db_d = mem[ram_idx];
            end else begin
                state_d     = EXT_WAIT;
                ext_req_d   = 1'b1;
                ext_addr_d  = AB;
                ext_wdata_d = DO;
                ext_we_d    = WE;
`ifdef BUS_RESP_TIMEOUT_EN
                cnt_d       = 8'd0;
`endif
            end
        end else begin
            if (ext_ack) begin
                if (!ext_we_q) begin
                    db_d = ext_rdata;
                end
                ext_req_d = 1'b0;
                state_d   = IDLE;
            end
`ifdef BUS_RESP_TIMEOUT_EN
            // An ack on the timeout edge completes normally and leaves err alone.
            else if (cnt_q == TMO_LAST) begin
                db_d      = 8'hFF;
                ext_req_d = 1'b0;
                err_d     = 1'b1;
                state_d   = IDLE;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            db_q        <= 8'h00;
            ext_req_q   <= 1'b0;
            ext_addr_q  <= 16'h0000;
            ext_wdata_q <= 8'h00;
            ext_we_q    <= 1'b0;
`ifdef BUS_RESP_TIMEOUT_EN
            cnt_q       <= 8'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            db_q        <= db_d;
            ext_req_q   <= ext_req_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            ext_we_q    <= ext_we_d;
`ifdef BUS_RESP_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    // RAM has no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= DO;
        end
    end

    assign RDY       = (state_q == IDLE);
    assign DB        = db_q;
    assign ext_req   = ext_req_q;
    assign ext_addr  = ext_addr_q;
    assign ext_wdata = ext_wdata_q;
    assign ext_we    = ext_we_q;

`ifdef BUS_RESP_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_resp.sv
// Scoreboard bench for bus_resp: directed CPU cycles, an ext_ack responder and a monitor.
module tb_bus_resp;

    logic        clk;
    logic        rst_n;
    logic [15:0] AB;
    logic [7:0]  DO;
    logic        WE;
    logic [7:0]  DB;
    logic        RDY;
    logic        ext_req;
    logic        ext_ack;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_we;
    logic [7:0]  ext_rdata;
    logic        err;

    bus_resp #(.RAM_PAGES(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .AB(AB), .DO(DO), .WE(WE), .DB(DB), .RDY(RDY),
        .ext_req(ext_req), .ext_ack(ext_ack), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_we(ext_we), .ext_rdata(ext_rdata), .err(err)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    logic [16:0] exp_q[$];   // {db_valid, db, stall_cycles}
    logic [24:0] ext_q[$];   // {ext_addr, ext_we, ext_wdata}
    logic [15:0] ack_q[$];   // {wait_cycles, rdata}; wait 255 = never ack

    logic cpu_valid = 1'b0;
    logic late_ack  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // External responder: acks on EXT_WAIT cycle wait+1, driven from the falling edge.
    logic [15:0] rsp_cfg;
    logic        rsp_busy = 1'b0;
    logic        rsp_has  = 1'b0;
    int          rsp_k    = 0;
    initial begin
        ext_ack   = 1'b0;
        ext_rdata = 8'hEE;
    end
    always @(negedge clk) begin
        ext_ack   = late_ack;
        ext_rdata = 8'hEE;
        if (!rst_n || !ext_req) begin
            rsp_busy = 1'b0;
        end else begin
            if (!rsp_busy) begin
                rsp_busy = 1'b1;
                rsp_k    = 0;
                rsp_has  = (ack_q.size() != 0);
                if (rsp_has) rsp_cfg = ack_q.pop_front();
            end
            rsp_k++;
            if (rsp_has && rsp_k == int'(rsp_cfg[15:8]) + 1) begin
                ext_ack   = 1'b1;
                ext_rdata = rsp_cfg[7:0];
            end
        end
    end

    // Monitor: completes the pending CPU cycle when RDY returns, checks ext_* latching and hold.
    logic        pending  = 1'b0;
    logic        prev_req = 1'b0;
    int          stalls   = 0;
    logic [16:0] mon_e;
    logic [24:0] mon_x;
    logic [24:0] cur_ext;
    always @(negedge clk) begin
        if (!rst_n) begin
            pending  = 1'b0;
            prev_req = 1'b0;
        end else begin
            if (pending) begin
                if (RDY) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_completion", 32'd1, 32'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e[16]) check("db", 32'(DB), 32'(mon_e[15:8]));
                        check("stall_cycles", 32'(stalls), 32'(mon_e[7:0]));
                    end
                    pending = 1'b0;
                end else begin
                    stalls++;
                end
            end
            if (RDY && cpu_valid) begin
                pending = 1'b1;
                stalls  = 0;
            end
            if (ext_req && !prev_req) begin
                cur_ext = {ext_addr, ext_we, ext_wdata};
                if (ext_q.size() == 0) begin
                    check("unexpected_ext_req", 32'd1, 32'd0);
                end else begin
                    mon_x = ext_q.pop_front();
                    check("ext_latch", 32'(cur_ext), 32'(mon_x));
                end
            end else if (ext_req) begin
                check("ext_hold", 32'({ext_addr, ext_we, ext_wdata}), 32'(cur_ext));
            end
            prev_req = ext_req;
        end
    end

    // Driver: presents one CPU cycle and holds it until accepted.
    task automatic drive(input logic [15:0] addr, input logic w, input logic [7:0] wd,
                         input int wt, input logic [7:0] rd,
                         input logic dbv, input logic [7:0] db, input logic [7:0] stl);
        logic acc;
        int   guard;
        AB        = addr;
        WE        = w;
        DO        = wd;
        cpu_valid = 1'b1;
        exp_q.push_back({dbv, db, stl});
        if (stl != 8'd0) begin
            ext_q.push_back({addr, w, wd});
            ack_q.push_back({8'(wt), rd});
        end
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 100) begin
            @(negedge clk);
            acc = RDY;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        cpu_valid = 1'b0;
        AB        = 16'h0050;
        WE        = 1'b0;
        DO        = 8'h00;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || pending) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"}, 32'(RDY), 32'd1);
        check({tag, "_db"}, 32'(DB), 32'h00);
        check({tag, "_ext_req"}, 32'(ext_req), 32'd0);
        check({tag, "_ext_addr"}, 32'(ext_addr), 32'h0000);
        check({tag, "_ext_wdata"}, 32'(ext_wdata), 32'h00);
        check({tag, "_ext_we"}, 32'(ext_we), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        AB    = 16'h0050;
        WE    = 1'b0;
        DO    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // addr, we, wdata, ack_wait, rdata, db_valid, exp_db, exp_stalls
        drive(16'h0012, 1'b1, 8'h5A, 0, 8'h00, 1'b0, 8'h00, 8'd0);
        drive(16'h0012, 1'b0, 8'h00, 0, 8'h00, 1'b1, 8'h5A, 8'd0);
        drive(16'h01FF, 1'b1, 8'h3C, 0, 8'h00, 1'b0, 8'h00, 8'd0);
        drive(16'h0050, 1'b1, 8'h00, 0, 8'h00, 1'b0, 8'h00, 8'd0);
        drive(16'h0012, 1'b1, 8'hA5, 0, 8'h00, 1'b1, 8'h5A, 8'd0);
        drive(16'h0012, 1'b0, 8'h00, 0, 8'h00, 1'b1, 8'hA5, 8'd0);
        drive(16'h8000, 1'b0, 8'h00, 2, 8'hC3, 1'b1, 8'hC3, 8'd3);
        drive(16'h4000, 1'b1, 8'h77, 0, 8'h99, 1'b1, 8'hC3, 8'd1);
        drive(16'h01FF, 1'b0, 8'h00, 0, 8'h00, 1'b1, 8'h3C, 8'd0);
        drive(16'hFFFF, 1'b0, 8'h00, 0, 8'h11, 1'b1, 8'h11, 8'd1);
        drive(16'h0200, 1'b0, 8'h00, 1, 8'h96, 1'b1, 8'h96, 8'd2);
        drive(16'h01FF, 1'b0, 8'h00, 0, 8'h00, 1'b1, 8'h3C, 8'd0);
        drive(16'h0100, 1'b1, 8'hE1, 0, 8'h00, 1'b0, 8'h00, 8'd0);
        drive(16'h0100, 1'b0, 8'h00, 0, 8'h00, 1'b1, 8'hE1, 8'd0);
        drive(16'hA000, 1'b1, 8'h01, 4, 8'h55, 1'b1, 8'hE1, 8'd5);
        drive(16'h0050, 1'b0, 8'h00, 0, 8'h00, 1'b1, 8'h00, 8'd0);
        drive(16'hC000, 1'b0, 8'h00, 0, 8'h2B, 1'b1, 8'h2B, 8'd1);
        drive(16'hD000, 1'b0, 8'h00, 0, 8'h3D, 1'b1, 8'h3D, 8'd1);
        drain();
        check("err_idle", 32'(err), 32'd0);

`ifdef BUS_RESP_TIMEOUT_EN
        drive(16'hB000, 1'b0, 8'h00, 15, 8'h42, 1'b1, 8'h42, 8'd16);
        drain();
        check("err_ack_on_timeout_edge", 32'(err), 32'd0);
        drive(16'h9000, 1'b0, 8'h00, 255, 8'h00, 1'b1, 8'hFF, 8'd16);
        drain();
        check("err_after_timeout", 32'(err), 32'd1);
        drive(16'h0012, 1'b0, 8'h00, 0, 8'h00, 1'b1, 8'hA5, 8'd0);
        drain();
        check("err_sticky", 32'(err), 32'd1);
`endif

        // Reset in the middle of an external read that is never acked.
        ext_q.push_back({16'h8000, 1'b0, 8'h00});
        AB = 16'h8000;
        WE = 1'b0;
        DO = 8'h00;
        @(posedge clk);
        #1;
        AB = 16'h0050;
        @(posedge clk);
        #1;
        check("mid_wait_rdy", 32'(RDY), 32'd0);
        check("mid_wait_ext_req", 32'(ext_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        late_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        late_ack = 1'b0;
        @(negedge clk);
        check_reset_outputs("late_ack");
        @(negedge clk);
        check_reset_outputs("after_late_ack");

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("ext_q_empty", 32'(ext_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_resp.md
BUS_RESP -- requirements
Module: bus_resp

Interface
REQ-001 Parameter: RAM_PAGES, default 2, number of 256-byte internal RAM pages mapped from 0x0000 (0x0000-0x01FF by default; zero page plus stack).
REQ-002 Parameter: TIMEOUT, default 16, ext_ack wait limit in cycles; range 2-255.
REQ-003 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: AB  in  16  CPU address bus; ADH:ADL, presented unregistered by the CPU each cycle.
REQ-006 Port: DO  in  8  CPU write data.
REQ-007 Port: WE  in  1  CPU write enable; 1 = write cycle.
REQ-008 Port: DB  out  8  registered read data to CPU.
REQ-009 Port: RDY  out  1  1 = cycle accepted and DB valid for the previously accepted read; 0 = CPU stalls.
REQ-010 Port: ext_req  out  1  external access request, level-held.
REQ-011 Port: ext_ack  in  1  external completion, one-cycle pulse.
REQ-012 Port: ext_addr, ext_wdata, ext_we  out  16/8/1  latched external access.
REQ-013 Port: ext_rdata  in  8  external read data, valid when ext_ack=1.
REQ-014 Port: err  out  1  sticky timeout flag.

Function
REQ-015 Accept rule: AB/WE/DO are sampled only at an edge where RDY=1; the CPU holds them while RDY=0, and the block ignores them during that time.
REQ-016 Decode rule: an address is internal when AB[15:8] < RAM_PAGES; every other address is external.
REQ-017 Internal read: DB = RAM[AB] on the cycle after acceptance, with zero wait states and RDY held at 1.
REQ-018 Internal write: RAM[AB] <= DO at the accept edge; DB loads the old contents (read-before-write).
REQ-019 Internal back-to-back accesses: a write followed by a read of the same address returns the new data.
REQ-020 State machine: IDLE, EXT_WAIT; RDY = (state==IDLE).
REQ-021 IDLE transition on an accepted external access: go to EXT_WAIT, assert ext_req, and latch ext_addr=AB, ext_we=WE, ext_wdata=DO.
REQ-022 EXT_WAIT: ext_req and the ext_* outputs are held stable until ext_ack is sampled high.
REQ-023 EXT_WAIT on ext_ack=1: DB <= ext_rdata for reads (DB unchanged for writes), ext_req <= 0, return to IDLE; RDY is 1 on the next cycle.
REQ-024 Minimum external latency: ack on the first EXT_WAIT cycle gives exactly 1 RDY=0 cycle; N wait cycles give N+1 RDY=0 cycles.
REQ-025 ext_ack sampled while ext_req=0 has no effect.
REQ-026 An accept in the RDY=1 cycle immediately following an external completion is permitted; this supports back-to-back external accesses.

Reset
REQ-027 rst_n=0 asynchronously forces: state IDLE, RDY=1, DB=0x00, ext_req=0, ext_addr=0x0000, ext_wdata=0x00, ext_we=0, err=0, timeout counter=0.
REQ-028 Reset mid-transaction abandons the access; no completion occurs and a late ext_ack is ignored per REQ-025.
REQ-029 RAM contents are not initialised by reset.

Configuration
REQ-030 Macro BUS_RESP_TIMEOUT_EN defined: a counter clears on entry to EXT_WAIT and increments each EXT_WAIT cycle.
REQ-031 With BUS_RESP_TIMEOUT_EN defined, if TIMEOUT EXT_WAIT cycles elapse without ext_ack: DB <= 0xFF, ext_req <= 0, err <= 1, return to IDLE.
REQ-032 With BUS_RESP_TIMEOUT_EN defined, ext_ack on the timeout edge wins as a normal completion with err unchanged; err clears only on reset.
REQ-033 Macro BUS_RESP_TIMEOUT_EN undefined: EXT_WAIT persists indefinitely, err is tied 0, and no counter logic exists.

Verification
REQ-034 Write 0x5A to 0x0012, then read 0x0012: DB=0x5A one cycle after the read is accepted, RDY never 0.
REQ-035 Read 0x8000 with ext_ack on the 3rd EXT_WAIT cycle, ext_rdata=0xC3: ext_addr=0x8000, RDY=0 for 3 cycles, DB=0xC3 with RDY=1.
REQ-036 Write 0x77 to 0x4000 with immediate ack, followed by an internal read of 0x01FF in the same RDY=1 cycle: ext_wdata=0x77, ext_we=1, single stall, internal read returns RAM[0x01FF].
REQ-037 With BUS_RESP_TIMEOUT_EN defined, read 0x9000 with no ack: after 16 stall cycles, DB=0xFF, err=1, RDY=1; err persists through later accesses.
REQ-038 rst_n pulsed low during EXT_WAIT, then ext_ack=1: all outputs at reset values, DB stays 0x00, no state change.
